uart_rx_sequencer: RTL and testbench

Receive-side control block for the UART receiver. It detects the start bit and validates it at mid-bit. It generates the bit-centred shift_strobe that clocks the 9-bit receive shift register (8 data bits LSB-first, then the stop bit). After the frame, it checks the captured stop bit and either pulses load_buffer to transfer the packet to the RX data buffer or flags a framing error.

---
 rtl/uart_rx_sequencer.sv | 141 ++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start-bit detect/validate, bit-centre shift strobes, stop-bit check.
// Define RX_MAJORITY_START_EN for 2-of-3 majority start-bit validation (adds one clock of latency).
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic stop_bit,
    output logic shift_strobe,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF_I = CLKS_PER_BIT / 2 - 1;

    localparam logic [CW-1:0] HALF     = CW'(HALF_I);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
`ifdef RX_MAJORITY_START_EN
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF_I - 1);
    localparam logic [CW-1:0] HALF_P1  = CW'(HALF_I + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RECV,
        S_CHECK,
        S_LOAD
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [3:0]      r_bit_cnt;
    logic            r_prev_in;
    logic            r_strobe;
    logic            r_load;
    logic            r_ferr;
    logic            r_busy;
    logic            w_edge;
    logic            w_start_low;

`ifdef RX_MAJORITY_START_EN
    logic [1:0]      r_maj;

    // Two earlier samples plus the live line form the 2-of-3 vote.
    assign w_start_low = (~r_maj[0] & ~r_maj[1]) |
                         (~r_maj[0] & ~serial_in) |
                         (~r_maj[1] & ~serial_in);
`else
    assign w_start_low = ~serial_in;
`endif

    assign w_edge        = r_prev_in & ~serial_in;
    assign shift_strobe  = r_strobe;
    assign load_buffer   = r_load;
    assign framing_error = r_ferr;
    assign busy          = r_busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_prev_in <= 1'b1;
            r_strobe  <= 1'b0;
            r_load    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef RX_MAJORITY_START_EN
            r_maj     <= '1;
`endif
        end else begin
            r_prev_in <= serial_in;
            r_strobe  <= 1'b0;
            r_load    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    r_clk_cnt <= r_clk_cnt + CW'(1);
`ifdef RX_MAJORITY_START_EN
                    if (r_clk_cnt == HALF_M1) r_maj[0] <= serial_in;
                    if (r_clk_cnt == HALF)    r_maj[1] <= serial_in;
                    if (r_clk_cnt == HALF_P1) begin
`else
                    if (r_clk_cnt == HALF) begin
`endif
                        if (w_start_low) begin
                            r_state   <= S_RECV;
                            r_clk_cnt <= '0;
                            r_bit_cnt <= '0;
                            r_ferr    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    // Strobe is registered one count early so it coincides with clk_cnt == LAST.
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd8) r_state <= S_CHECK;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                        if (r_clk_cnt == PRE_LAST) r_strobe <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (stop_bit) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ferr  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: expected strobe/load cycles queued at stimulus time.
module tb_uart_rx_sequencer;

    localparam int CLKS = 10;
    localparam int HALF = CLKS / 2 - 1;
`ifdef RX_MAJORITY_START_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    localparam int FIRST = HALF + 1 + CLKS + M;
    localparam int LOADO = FIRST + 8 * CLKS + 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b1;
    logic stop_bit;
    logic shift_strobe, load_buffer, framing_error, busy;
    logic [8:0] sr = '0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int q_strb[$];
    int q_load[$];
    int t;

    uart_rx_sequencer #(.CLKS_PER_BIT(CLKS)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .stop_bit     (stop_bit),
        .shift_strobe (shift_strobe),
        .load_buffer  (load_buffer),
        .framing_error(framing_error),
        .busy         (busy)
    );

    assign stop_bit = sr[8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shift_strobe) sr <= {serial_in, sr[8:1]};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_strobe !== 1'b0) begin
                if (q_strb.size() > 0) check("strobe_cyc", cyc, q_strb.pop_front());
                else                   check("strobe_extra", cyc, -1);
            end
            if (load_buffer !== 1'b0) begin
                if (q_load.size() > 0) check("load_cyc", cyc, q_load.pop_front());
                else                   check("load_extra", cyc, -1);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drives one 10-bit frame starting at the current negedge; rst_at/hi_at are offsets from the start (0 = unused).
    task automatic send_frame(input logic [7:0] d, input logic stp, input int rst_at, input int hi_at);
        int t0;
        logic [9:0] bits;
        bits = {stp, d, 1'b0};
        t0 = cyc;
        for (int k = 0; k < 9; k++)
            if (rst_at == 0 || FIRST + k * CLKS < rst_at) q_strb.push_back(t0 + FIRST + k * CLKS);
        if (stp && rst_at == 0) q_load.push_back(t0 + LOADO);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CLKS; c++) begin
                if (rst_at != 0 && cyc == t0 + rst_at) begin
                    n_rst = 1'b0;
                    serial_in = 1'b1;
                    #1;
                    check("rst_strobe", 32'(shift_strobe), 0);
                    check("rst_load", 32'(load_buffer), 0);
                    check("rst_ferr", 32'(framing_error), 0);
                    check("rst_busy", 32'(busy), 0);
                    return;
                end
                serial_in = (hi_at != 0 && cyc == t0 + hi_at) ? 1'b1 : bits[b];
                @(negedge clk);
            end
        end
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_strb_left"}, q_strb.size(), 0);
        check({tag, "_load_left"}, q_load.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_strobe", 32'(shift_strobe), 0);
        check("reset_load", 32'(load_buffer), 0);
        check("reset_ferr", 32'(framing_error), 0);
        check("reset_busy", 32'(busy), 0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Valid frame 0xA5, stop=1
        t = cyc;
        fork
            send_frame(8'hA5, 1'b1, 0, 0);
            begin
                wait_cyc(t + 1);         check("busy_start", 32'(busy), 1);
                wait_cyc(t + LOADO);     check("busy_load", 32'(busy), 1);
                wait_cyc(t + LOADO + 1); check("busy_end", 32'(busy), 0);
            end
        join
        check("sr_a5", 32'(sr), 32'h1A5);
        check("ferr_ok", 32'(framing_error), 0);
        check_queues("f1");

        // Same frame, stop=0
        t = cyc;
        fork
            send_frame(8'hA5, 1'b0, 0, 0);
            begin
                wait_cyc(t + LOADO - 1); check("ferr_pre", 32'(framing_error), 0);
                wait_cyc(t + LOADO);     check("ferr_set", 32'(framing_error), 1);
            end
        join
        check("sr_a5_bad", 32'(sr), 32'h0A5);
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        check_queues("f2");

        // 3-cycle low glitch: false start, sticky error untouched
        t = cyc;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        wait_cyc(t + 5 + M); check("glitch_busy_hi", 32'(busy), 1);
        wait_cyc(t + 6 + M); check("glitch_busy_lo", 32'(busy), 0);
        check("glitch_ferr", 32'(framing_error), 1);
        repeat (5) @(negedge clk);

        // Next valid frame clears the error at START->RECV
        t = cyc;
        fork
            send_frame(8'h3C, 1'b1, 0, 0);
            begin
                wait_cyc(t + HALF + 1 + M); check("ferr_hold", 32'(framing_error), 1);
                wait_cyc(t + HALF + 2 + M); check("ferr_clear", 32'(framing_error), 0);
            end
        join
        check("sr_3c", 32'(sr), 32'h13C);
        repeat (5) @(negedge clk);
        check_queues("f3");

        // Reset mid-frame, then a fresh frame
        send_frame(8'hA5, 1'b1, 50, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        check_queues("rst");
        send_frame(8'h5A, 1'b1, 0, 0);
        check("sr_5a", 32'(sr), 32'h15A);
        repeat (5) @(negedge clk);
        check_queues("f4");

        // Back-to-back frames
        send_frame(8'h81, 1'b1, 0, 0);
        check("sr_81", 32'(sr), 32'h181);
        send_frame(8'h7E, 1'b1, 0, 0);
        check("sr_7e", 32'(sr), 32'h17E);
        repeat (5) @(negedge clk);
        check_queues("b2b");

        // Break: line held low
        send_frame(8'h00, 1'b0, 0, 0);
        repeat (200) @(negedge clk);
        check("break_busy", 32'(busy), 0);
        check("break_ferr", 32'(framing_error), 1);
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        check_queues("brk");

`ifdef RX_MAJORITY_START_EN
        // One-cycle high at clk_cnt==HALF is outvoted
        send_frame(8'hC3, 1'b1, 0, HALF + 1);
        check("sr_c3", 32'(sr), 32'h1C3);
        repeat (5) @(negedge clk);
        check_queues("maj");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
